// File: rtl/dffram_pin_pkg.sv
// -----------------------------------------------------------------------------
// dffram_pin_pkg
// Shared definitions for the DFF-RAM pin-protocol host:
//   - state_t    : host FSM states
//   - pin fields : bit positions inside the 8-bit uio pin word
//   - mk_pin()   : packs {addr, en, we} into a uio pin word
// -----------------------------------------------------------------------------
package dffram_pin_pkg;

    localparam int ADDR_W   = 3;   // word address width, fixed by the pin map
    localparam int DATA_W   = 32;  // request/response word width
    localparam int PIN_W    = 8;   // width of each pin bus
    localparam int LANES    = 4;   // byte lanes per word

    // uio pin word layout: [7:5]=address, [4]=EN, [3:0]=one-hot WE lane
    localparam int WE_LSB   = 0;
    localparam int WE_W     = 4;
    localparam int EN_BIT   = 4;
    localparam int ADDR_LSB = 5;

    localparam logic [PIN_W-1:0] PIN_IDLE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        WR_BYTE,
        RD_CMD,
        RD_WAIT,
        RD_CAP,
        GAP_S,
        RESP
    } state_t;

    function automatic logic [PIN_W-1:0] mk_pin(
        input logic [ADDR_W-1:0] addr,
        input logic              en,
        input logic [WE_W-1:0]   we
    );
        logic [PIN_W-1:0] p;
        p                       = PIN_IDLE;
        p[ADDR_LSB +: ADDR_W]   = addr;
        p[EN_BIT]               = en;
        p[WE_LSB +: WE_W]       = we;
        return p;
    endfunction

endpackage

// File: rtl/dffram_pin_host_if.sv
// -----------------------------------------------------------------------------
// dffram_pin_host_if
// Word-level request/response bus between a requester and dffram_pin_host.
//   req_valid/req_ready : request handshake (accept on both high)
//   req_write           : 1 = write, 0 = read
//   req_addr            : word address
//   req_wdata/req_wmask : write word and byte-lane enables
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : read word (held between reads)
//   busy                : host not idle
// Modports: master = requester side, slave = host side.
// -----------------------------------------------------------------------------
interface dffram_pin_host_if;
    import dffram_pin_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [LANES-1:0]    req_wmask;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/dffram_pin_rx_shift.sv
// -----------------------------------------------------------------------------
// dffram_pin_rx_shift
// Four-byte capture shifter for read data arriving byte-serially on pin_uo.
// Each load shifts the new byte in at the top, so after four loads the first
// byte received sits in [7:0] and the fourth in [31:24].
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : clear the capture register (new request)
//   i_load     : shift i_byte in
//   i_byte     : byte sampled from the RAM pins
//   o_data     : assembled 32-bit word
// -----------------------------------------------------------------------------
module dffram_pin_rx_shift
    import dffram_pin_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [PIN_W-1:0]  i_byte,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= {i_byte, r_data[DATA_W-1:PIN_W]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/dffram_pin_host.sv
// -----------------------------------------------------------------------------
// dffram_pin_host
// Host-side initiator for the 8x32 DFF-RAM pin protocol. Converts word-level
// requests into byte-serial pin cycles and reassembles 4-byte read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response interface (slave modport)
//   pin_ui     : write byte driven to RAM ui_in (registered)
//   pin_uio    : {addr, EN, WE one-hot} driven to RAM uio_in (registered)
//   pin_uo     : read byte sampled from RAM uo_out
// Parameters:
//   READ_LAT : cycles from the read-command pin cycle to the first valid byte (1..7)
//   GAP      : idle pin cycles inserted after every request (0..3)
// Timing: pins for the first transfer cycle are loaded on the accept edge;
// rsp_valid is registered out of RESP, so it is visible in the IDLE cycle
// that follows RESP.
// -----------------------------------------------------------------------------
module dffram_pin_host
    import dffram_pin_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned GAP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dffram_pin_host_if.slave  bus,
    output logic [PIN_W-1:0]  pin_ui,
    output logic [PIN_W-1:0]  pin_uio,
    input  logic [PIN_W-1:0]  pin_uo
);

    // Counter preload values; guarded so out-of-range casts never occur.
    localparam int          GAP_N     = (GAP > 0) ? int'(GAP) - 1 : 0;
    localparam int          WAIT_N    = (READ_LAT > 1) ? int'(READ_LAT) - 2 : 0;
    localparam logic [2:0]  GAP_LOAD  = 3'(GAP_N);
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_N);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [LANES-1:0]   r_wmask_rem;   // lanes not yet sent (excludes current)
    logic               r_write;
    logic [2:0]         r_cnt;         // wait / capture / gap counter
    logic [PIN_W-1:0]   r_pin_ui;
    logic [PIN_W-1:0]   r_pin_uio;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic [LANES-1:0]   w_search_mask;
    logic [DATA_W-1:0]  w_search_data;
    logic [1:0]         w_lane;
    logic               w_found;
    logic [LANES-1:0]   w_mask_clr;
    logic [PIN_W-1:0]   w_lane_byte;
    logic               w_accept;
    logic               w_cap;
    logic [DATA_W-1:0]  w_rx_data;

    // State entered once the pin transfer of a request is finished.
    function automatic state_t post_xfer_state();
        return (GAP > 0) ? GAP_S : RESP;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_cap    = (r_state == RD_CAP);

    // In IDLE the search looks at the incoming request so the first lane can
    // be driven on the accept edge; afterwards it walks the remaining mask.
    assign w_search_mask = (r_state == IDLE) ? bus.req_wmask : r_wmask_rem;
    assign w_search_data = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_lane  = 2'd0;
        w_found = 1'b0;
        // Descending scan: the last hit is the lowest set lane.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_search_mask[i]) begin
                w_lane  = 2'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_mask_clr  = w_search_mask & ~(4'b0001 << w_lane);
    assign w_lane_byte = w_search_data[{w_lane, 3'b000} +: PIN_W];

    dffram_pin_rx_shift u_rx_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_load  (w_cap),
        .i_byte  (pin_uo),
        .o_data  (w_rx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask_rem <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_pin_ui    <= PIN_IDLE;
            r_pin_uio   <= PIN_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_write <= bus.req_write;
                        if (bus.req_write) begin
                            if (w_found) begin
                                r_pin_uio   <= mk_pin(bus.req_addr, 1'b1, 4'b0001 << w_lane);
                                r_pin_ui    <= w_lane_byte;
                                r_wmask_rem <= w_mask_clr;
                                r_state     <= WR_BYTE;
                            end else begin
                                // Empty mask: no pin activity at all.
                                r_cnt   <= GAP_LOAD;
                                r_state <= post_xfer_state();
                            end
                        end else begin
                            r_pin_uio <= mk_pin(bus.req_addr, 1'b1, 4'b0000);
                            r_pin_ui  <= PIN_IDLE;
                            r_state   <= RD_CMD;
                        end
                    end
                end

                WR_BYTE: begin
                    if (w_found) begin
                        r_pin_uio   <= mk_pin(r_addr, 1'b1, 4'b0001 << w_lane);
                        r_pin_ui    <= w_lane_byte;
                        r_wmask_rem <= w_mask_clr;
                    end else begin
                        r_pin_uio <= PIN_IDLE;
                        r_pin_ui  <= PIN_IDLE;
                        r_cnt     <= GAP_LOAD;
                        r_state   <= post_xfer_state();
                    end
                end

                RD_CMD: begin
                    r_pin_uio <= PIN_IDLE;
                    r_pin_ui  <= PIN_IDLE;
                    if (READ_LAT > 1) begin
                        r_cnt   <= WAIT_LOAD;
                        r_state <= RD_WAIT;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= RD_CAP;
                    end
                end

                RD_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= RD_CAP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                // The shifter loads every RD_CAP cycle; the count only tracks
                // when the fourth byte has gone in.
                RD_CAP: begin
                    if (r_cnt == 3'd3) begin
                        r_cnt   <= GAP_LOAD;
                        r_state <= post_xfer_state();
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                GAP_S: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                RESP: begin
                    r_rsp_valid <= 1'b1;
                    if (!r_write) begin
                        r_rsp_rdata <= w_rx_data;
                    end
                    r_state <= IDLE;
                end

                default: begin
                    r_pin_uio <= PIN_IDLE;
                    r_pin_ui  <= PIN_IDLE;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign pin_ui        = r_pin_ui;
    assign pin_uio       = r_pin_uio;
    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
